// File: rtl/float_divider_seq_if.sv
// -----------------------------------------------------------------------------
// float_divider_seq_if
//   Request/response bundle for the sequential single-precision divider.
//
//   Signals (named from the divider's point of view):
//     i_start       : request, sampled only while the divider is idle
//     i_dividend    : IEEE-754 single dividend, sampled with i_start
//     i_divisor     : IEEE-754 single divisor, sampled with i_start
//     o_busy        : high while an operation is in progress
//     o_done        : one-cycle pulse, o_result valid from this cycle
//     o_result      : quotient, held until the next o_done or reset
//     o_div_by_zero : divide-by-zero flag, valid with o_done
//
//   Modports: master (requester), slave (divider).
// -----------------------------------------------------------------------------
interface float_divider_seq_if;
   logic        i_start;
   logic [31:0] i_dividend;
   logic [31:0] i_divisor;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_result;
   logic        o_div_by_zero;

   modport master (
      output i_start, i_dividend, i_divisor,
      input  o_busy, o_done, o_result, o_div_by_zero
   );

   modport slave (
      input  i_start, i_dividend, i_divisor,
      output o_busy, o_done, o_result, o_div_by_zero
   );
endinterface : float_divider_seq_if

// File: rtl/float_divider_seq.sv
// -----------------------------------------------------------------------------
// float_divider_seq
//   Sequential IEEE-754 single-precision divider. One restoring-division step
//   per clock produces a 26-bit mantissa quotient MSB-first, then a single
//   rounding cycle normalises, rounds half-up and loads the result.
//   Latency: o_done rises 27 edges after the edge that samples i_start.
//   Exponents wrap modulo 256; no special-value handling beyond the optional
//   zero-divisor detection below.
//
//   Ports:
//     i_clk   : rising-edge clock for all state
//     i_rst_n : asynchronous active-low reset
//     bus     : float_divider_seq_if.slave (start/operands in, busy/done/
//               result/div-by-zero out)
//
//   Configuration:
//     FDIV_ZERO_DETECT_EN : when defined, a divisor with a zero exponent field
//                           skips the iteration phase and returns
//                           {sign, 8'hFF, 23'b0} with o_div_by_zero set one
//                           edge after the start. When undefined, such a
//                           divisor is treated as a normal number (hidden 1)
//                           and o_div_by_zero is constant 0.
// -----------------------------------------------------------------------------
module float_divider_seq (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   float_divider_seq_if.slave        bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DIV   = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;

   localparam logic [4:0] LAST_STEP = 5'd25;

   logic [1:0]  r_state;
   logic [4:0]  r_cnt;
   logic [24:0] r_rem;      // partial remainder, always < 2 * divisor
   logic [23:0] r_div;      // divisor mantissa with hidden 1
   logic [25:0] r_quo;      // quotient bits, shifted in MSB-first
   logic        r_sign;
   logic [7:0]  r_exp_a;
   logic [7:0]  r_exp_b;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_result;

   logic        w_ge;
   logic [23:0] w_rem_next;
   logic [22:0] w_mant_pre;
   logic        w_rnd_bit;
   logic [7:0]  w_exp_pre;
   logic [23:0] w_mant_sum;
   logic [7:0]  w_exp;
   logic [31:0] w_result;

`ifdef FDIV_ZERO_DETECT_EN
   logic        r_zero;     // current operation has a zero-exponent divisor
   logic        r_dbz;
   logic        w_div_zero;

   assign w_div_zero = (bus.i_divisor[30:23] == 8'h00);
`endif

   // One restoring step. When the subtraction succeeds its true result is
   // below the divisor, so the low 24 bits are exact; when it fails the
   // remainder itself is below the divisor. Either way bit 24 is zero.
   assign w_ge       = (r_rem >= {1'b0, r_div});
   assign w_rem_next = w_ge ? (r_rem[23:0] - r_div) : r_rem[23:0];

   // Normalise, round half-up and assemble the result.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      w_mant_pre = r_quo[23:1];
      w_rnd_bit  = r_quo[0];
      w_exp_pre  = r_exp_a - r_exp_b + 8'd126;
      if (r_quo[25]) begin
         w_mant_pre = r_quo[24:2];
         w_rnd_bit  = r_quo[1];
         w_exp_pre  = r_exp_a - r_exp_b + 8'd127;
      end
      // A carry out of the mantissa leaves the low 23 bits at zero and
      // bumps the exponent by one.
      w_mant_sum = {1'b0, w_mant_pre} + {23'd0, w_rnd_bit};
      w_exp      = w_exp_pre + {7'd0, w_mant_sum[23]};
      w_result   = {r_sign, w_exp, w_mant_sum[22:0]};
`ifdef FDIV_ZERO_DETECT_EN
      if (r_zero) begin
         w_result = {r_sign, 8'hFF, 23'd0};
      end
`endif
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: every register, datapath included, is reset so an aborted
         // operation leaves nothing behind for the next one.
         r_state  <= S_IDLE;
         r_cnt    <= 5'd0;
         r_rem    <= 25'd0;
         r_div    <= 24'd0;
         r_quo    <= 26'd0;
         r_sign   <= 1'b0;
         r_exp_a  <= 8'd0;
         r_exp_b  <= 8'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= 32'd0;
`ifdef FDIV_ZERO_DETECT_EN
         r_zero   <= 1'b0;
         r_dbz    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_sign  <= bus.i_dividend[31] ^ bus.i_divisor[31];
                  r_exp_a <= bus.i_dividend[30:23];
                  r_exp_b <= bus.i_divisor[30:23];
                  r_rem   <= {2'b01, bus.i_dividend[22:0]};
                  r_div   <= {1'b1, bus.i_divisor[22:0]};
                  r_quo   <= 26'd0;
                  r_cnt   <= 5'd0;
                  r_busy  <= 1'b1;
`ifdef FDIV_ZERO_DETECT_EN
                  r_zero  <= w_div_zero;
                  r_state <= w_div_zero ? S_ROUND : S_DIV;
`else
                  r_state <= S_DIV;
`endif
               end
            end
            S_DIV: begin
               r_quo <= {r_quo[24:0], w_ge};
               r_rem <= {w_rem_next, 1'b0};
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == LAST_STEP) begin
                  r_state <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_result <= w_result;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
`ifdef FDIV_ZERO_DETECT_EN
               r_dbz    <= r_zero;
               r_zero   <= 1'b0;
`endif
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_busy   = r_busy;
   assign bus.o_done   = r_done;
   assign bus.o_result = r_result;
`ifdef FDIV_ZERO_DETECT_EN
   assign bus.o_div_by_zero = r_dbz;
`else
   assign bus.o_div_by_zero = 1'b0;
`endif

endmodule : float_divider_seq

// File: tb/tb_float_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_float_divider_seq
//   Directed bench for float_divider_seq. Expected quotients are hand-derived
//   constants; latency is counted in clock edges from the start-sampling edge.
//   Follows FDIV_ZERO_DETECT_EN for the zero-divisor expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_float_divider_seq;

   logic clk;
   logic rst_n;
   int   n_compared;
   int   n_mismatched;

   float_divider_seq_if bus ();

   float_divider_seq dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

`ifdef FDIV_ZERO_DETECT_EN
   localparam bit ZERO_DETECT = 1'b1;
`else
   localparam bit ZERO_DETECT = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present a request in the low phase; returns just after the sampling edge.
   task automatic launch(input string tag, input logic [31:0] a,
                         input logic [31:0] b);
      @(negedge clk);
      bus.i_start    = 1'b1;
      bus.i_dividend = a;
      bus.i_divisor  = b;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      check({tag, "_busy_set"}, {31'd0, bus.o_busy}, 32'd1);
      check({tag, "_done_low"}, {31'd0, bus.o_done}, 32'd0);
   endtask

   // Count edges until o_done; optionally re-issue a start at edge 5 that the
   // busy divider must ignore. Returns in the done cycle.
   task automatic wait_done(input string tag, input logic [31:0] exp_res,
                            input int exp_lat, input bit exp_dbz,
                            input bit inject);
      int n;
      bit busy_ok;
      n       = 0;
      busy_ok = 1'b1;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (inject && n == 4) begin
            bus.i_start    = 1'b1;
            bus.i_dividend = 32'h3F80_0000;
            bus.i_divisor  = 32'h4040_0000;
         end
         if (inject && n == 5) begin
            bus.i_start = 1'b0;
         end
         if (bus.o_done) break;
         if (!bus.o_busy) busy_ok = 1'b0;
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
      check({tag, "_result"}, bus.o_result, exp_res);
      check({tag, "_dbz"}, {31'd0, bus.o_div_by_zero}, {31'd0, exp_dbz});
      check({tag, "_busy_clr"}, {31'd0, bus.o_busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit done_seen;
      n_compared     = 0;
      n_mismatched   = 0;
      rst_n          = 1'b0;
      bus.i_start    = 1'b0;
      bus.i_dividend = 32'd0;
      bus.i_divisor  = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",   {31'd0, bus.o_busy},        32'd0);
      check("rst_done",   {31'd0, bus.o_done},        32'd0);
      check("rst_result", bus.o_result,               32'd0);
      check("rst_dbz",    {31'd0, bus.o_div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic quotients.
      launch("six_by_two", 32'h40C0_0000, 32'h4000_0000);
      wait_done("six_by_two", 32'h4040_0000, 27, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_done",   {31'd0, bus.o_done}, 32'd0);
      check("hold_result", bus.o_result, 32'h4040_0000);

      launch("one_third", 32'h3F80_0000, 32'h4040_0000);
      wait_done("one_third", 32'h3EAA_AAAB, 27, 1'b0, 1'b0);

      launch("one_by_one", 32'h3F80_0000, 32'h3F80_0000);
      wait_done("one_by_one", 32'h3F80_0000, 27, 1'b0, 1'b0);

      launch("neg_sign", 32'hBFC0_0000, 32'h3F00_0000);
      wait_done("neg_sign", 32'hC040_0000, 27, 1'b0, 1'b0);

      // Exponent wraps modulo 256: 1 - 254 + 127 = 130.
      launch("exp_wrap", 32'h0080_0000, 32'h7F00_0000);
      wait_done("exp_wrap", 32'h4100_0000, 27, 1'b0, 1'b0);

      // Start while busy is ignored; start in the done cycle is accepted.
      launch("ignore_start", 32'h40C0_0000, 32'h4000_0000);
      wait_done("ignore_start", 32'h4040_0000, 27, 1'b0, 1'b1);
      launch("done_cycle_start", 32'h3F80_0000, 32'h4040_0000);
      wait_done("done_cycle_start", 32'h3EAA_AAAB, 27, 1'b0, 1'b0);

      // Zero-exponent divisor.
      launch("div_zero", 32'h4000_0000, 32'h0000_0000);
      wait_done("div_zero", 32'h7F80_0000, ZERO_DETECT ? 1 : 27,
                ZERO_DETECT, 1'b0);
      launch("dbz_clear", 32'h40C0_0000, 32'h4000_0000);
      wait_done("dbz_clear", 32'h4040_0000, 27, 1'b0, 1'b0);

      // Reset mid-operation at edge 10.
      launch("abort", 32'h40C0_0000, 32'h4000_0000);
      repeat (10) @(posedge clk);
      #1;
      check("abort_busy_mid", {31'd0, bus.o_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy",   {31'd0, bus.o_busy},        32'd0);
      check("abort_done",   {31'd0, bus.o_done},        32'd0);
      check("abort_result", bus.o_result,               32'd0);
      check("abort_dbz",    {31'd0, bus.o_div_by_zero}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.o_done) done_seen = 1'b1;
      end
      check("abort_no_done", {31'd0, done_seen}, 32'd0);
      check("abort_result_held", bus.o_result, 32'd0);
      launch("after_reset", 32'h3F80_0000, 32'h4040_0000);
      wait_done("after_reset", 32'h3EAA_AAAB, 27, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_float_divider_seq

// File: doc/float_divider_seq.md
FLOAT_DIVIDER_SEQ -- requirements
Module: float_divider_seq

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst_n  input  1  asynchronous active-low reset.
REQ-004 Start  input  1  request; sampled only in IDLE.
REQ-005 Dividend  input  32  IEEE-754 single, sampled with Start.
REQ-006 Divisor  input  32  IEEE-754 single, sampled with Start.
REQ-007 Busy  output  1  high while an operation is in progress.
REQ-008 Done  output  1  one-cycle pulse; Result valid from this cycle.
REQ-009 Result  output  32  quotient; held until next Done or reset.
REQ-010 DivByZero  output  1  divide-by-zero flag, valid with Done.

Function
REQ-011 SHALL implement states IDLE, DIV, ROUND: IDLE->DIV on Start; DIV->ROUND after 26 iterations; ROUND->IDLE unconditionally.
REQ-012 Edge sampling Start in IDLE SHALL register operands, load remainder {1,Dividend[22:0]} and divisor {1,Divisor[22:0]}, clear the iteration counter and set Busy.
REQ-013 Each DIV edge SHALL perform one restoring step, producing one quotient bit MSB-first; 26 steps yield q[25:0] = floor({1,ma}*2^25/{1,mb}).
REQ-014 If q[25]=1: mantissa = q[24:2], round bit = q[1], exponent = Ea-Eb+127; else mantissa = q[23:1], round bit = q[0], exponent = Ea-Eb+126.
REQ-015 Rounding SHALL be round-half-up: add the round bit to the 23-bit mantissa; on carry-out the mantissa becomes 0 and the exponent increments by 1.
REQ-016 Exponent arithmetic SHALL be 8-bit modulo 256; no overflow, underflow, denormal, NaN or infinity handling except REQ-024.
REQ-017 Result[31] SHALL be Dividend[31] XOR Divisor[31].
REQ-018 ROUND edge (27 edges after the Start-sampling edge) SHALL load Result, set Done=1 and clear Busy; Done SHALL return to 0 on the next edge.
REQ-019 Start while Busy SHALL be ignored, with no effect on operands, Result or Done.
REQ-020 Start high in the Done cycle SHALL be accepted, since the FSM is in IDLE.
REQ-021 Equal mantissas SHALL give q[25]=1 and mantissa 0, e.g. 1.0/1.0 = 0x3F800000.

Reset
REQ-022 Rst_n low SHALL immediately force IDLE, Busy=0, Done=0, Result=0, DivByZero=0, counter=0 and clear internal registers, including mid-operation; the aborted operation SHALL produce no Done.
REQ-023 After Rst_n deasserts, the first Start SHALL complete normally with full latency.

Configuration
REQ-024 With FDIV_ZERO_DETECT_EN defined, Divisor[30:23]=0 sampled with Start SHALL skip DIV: the next edge loads Result={sign,8'hFF,23'b0}, DivByZero=1, Done=1 and Busy=0. A normal operation SHALL clear DivByZero at its Done.
REQ-025 Without FDIV_ZERO_DETECT_EN, a zero-exponent divisor SHALL be treated as hidden-1 normal with full 27-edge latency, and DivByZero SHALL be constant 0.

Verification
REQ-026 0x40C00000 / 0x40000000 (6.0/2.0) -> Result 0x40400000, Done exactly 27 edges after Start, Busy high in between.
REQ-027 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (round-up applied); 0x3F800000 / 0x3F800000 -> 0x3F800000.
REQ-028 0xBFC00000 / 0x3F000000 (-1.5/0.5) -> 0xC0400000.
REQ-029 Start 6.0/2.0, then Start with 0x3F800000/0x40400000 at edge 5 -> single Done at edge 27 with 0x40400000; Start in the Done cycle -> new operation accepted.
REQ-030 Rst_n low at edge 10 of an operation -> Busy/Done/Result 0 immediately, no Done; a later Start completes normally.
REQ-031 0x40000000 / 0x00000000 -> with macro: 0x7F800000, DivByZero=1, Done 1 edge after Start; without macro: Done at 27 edges, DivByZero=0.
